// File: rtl/tmds_multi_encoder_pkg.sv
// Shared types, symbol tables and the stage-1 transition-minimising helper
// for the N-lane TMDS encoder.
// Contents: mode_e, CTRL_SYM, VGUARD_SYM_A/B, TERC4_SYM (only when
// TMDS_TERC4_EN is defined), qm_t payload and tmds_qm().
package tmds_multi_encoder_pkg;

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned QM_W   = 9;
  localparam int unsigned DISP_W = 5;

  typedef enum logic [1:0] {
    MODE_CTRL   = 2'd0,
    MODE_VIDEO  = 2'd1,
    MODE_VGUARD = 2'd2,
    MODE_ISLAND = 2'd3
  } mode_e;

  // Indexed by {c1,c0}
  localparam logic [SYM_W-1:0] CTRL_SYM [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [SYM_W-1:0] VGUARD_SYM_A = 10'b1011001100;
  localparam logic [SYM_W-1:0] VGUARD_SYM_B = 10'b0100110011;

`ifdef TMDS_TERC4_EN
  localparam logic [SYM_W-1:0] TERC4_SYM [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
`endif

  // Stage-1 result: q_m word and its disparity 2*ones-8 (range -8..+8)
  typedef struct packed {
    logic [QM_W-1:0]          qm;
    logic signed [DISP_W-1:0] disp;
  } qm_t;

  function automatic qm_t tmds_qm(input logic [7:0] d);
    qm_t               r;
    logic [3:0]        n1;
    logic [3:0]        n_qm;
    logic              xnor_sel;
    logic signed [5:0] twice;
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 = n1 + 4'(d[i]);
    xnor_sel = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    r.qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      r.qm[i] = xnor_sel ? ~(r.qm[i-1] ^ d[i]) : (r.qm[i-1] ^ d[i]);
    r.qm[8] = ~xnor_sel;
    n_qm = '0;
    for (int i = 0; i < 8; i++) n_qm = n_qm + 4'(r.qm[i]);
    twice  = $signed({1'b0, n_qm, 1'b0}) - 6'sd8;
    r.disp = twice[DISP_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/tmds_multi_encoder_if.sv
// Symbol-slot bus between the timing generator (master) and the encoder
// (slave). Carries per-lane video/control/TERC4 inputs and the encoded
// 10-bit symbols; lane i occupies slice [W*i +: W] of each vector.
interface tmds_multi_encoder_if #(
  parameter int unsigned NUM_CH = 3
);
  import tmds_multi_encoder_pkg::*;

  logic                  in_valid;
  mode_e                 in_mode;
  logic [NUM_CH*8-1:0]   in_data;
  logic [NUM_CH*2-1:0]   in_ctrl;
  logic [NUM_CH*4-1:0]   in_terc4;
  logic                  out_valid;
  logic [NUM_CH*10-1:0]  out_symbols;

  modport master (
    output in_valid, in_mode, in_data, in_ctrl, in_terc4,
    input  out_valid, out_symbols
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_ctrl, in_terc4,
    output out_valid, out_symbols
  );
endinterface

// File: rtl/tmds_multi_encoder_lane_enc.sv
// One TMDS lane: stage 1 registers q_m/disparity and the slot side-band,
// stage 2 applies DC balancing (or a table symbol) and owns the lane bias.
// Ports: clk, rst (sync, active-high), adv1_i/adv2_i stage-advance strobes,
// mode_i, data_i, ctrl_i, terc4_i (only with TMDS_TERC4_EN), sym_o.
// LANE_IDX selects the guard-band symbol (lane 1 differs from the rest).
module tmds_multi_encoder_lane_enc
  import tmds_multi_encoder_pkg::*;
#(
  parameter int unsigned LANE_IDX = 0,
  parameter int unsigned BIAS_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv1_i,
  input  logic             adv2_i,
  input  mode_e            mode_i,
  input  logic [7:0]       data_i,
  input  logic [1:0]       ctrl_i,
`ifdef TMDS_TERC4_EN
  input  logic [3:0]       terc4_i,
`endif
  output logic [SYM_W-1:0] sym_o
);

  localparam logic signed [BIAS_W-1:0] TWO = BIAS_W'(2);

  qm_t                      qm_c;
  logic [QM_W-1:0]          qm_q;
  logic signed [DISP_W-1:0] disp_q;
  mode_e                    mode_q;
  logic [1:0]               ctrl_q;
`ifdef TMDS_TERC4_EN
  logic [3:0]               terc4_q;
`endif
  logic [SYM_W-1:0]         sym_q, sym_d;
  logic signed [BIAS_W-1:0] bias_q, bias_d;
  logic signed [BIAS_W-1:0] disp_b;
  logic                     q8;
  logic [SYM_W-1:0]         tbl_sym;

  assign qm_c   = tmds_qm(data_i);
  assign disp_b = BIAS_W'(disp_q);
  assign q8     = qm_q[8];

  // Stage 1: capture q_m and side-band only for valid slots
  always_ff @(posedge clk) begin
    if (rst) begin
      qm_q    <= '0;
      disp_q  <= '0;
      mode_q  <= MODE_CTRL;
      ctrl_q  <= '0;
`ifdef TMDS_TERC4_EN
      terc4_q <= '0;
`endif
    end else if (adv1_i) begin
      qm_q    <= qm_c.qm;
      disp_q  <= qm_c.disp;
      mode_q  <= mode_i;
      ctrl_q  <= ctrl_i;
`ifdef TMDS_TERC4_EN
      terc4_q <= terc4_i;
`endif
    end
  end

  // Island symbol: TERC4 when built, otherwise the control symbol
  always_comb begin
`ifdef TMDS_TERC4_EN
    tbl_sym = TERC4_SYM[terc4_q];
`else
    tbl_sym = CTRL_SYM[ctrl_q];
`endif
  end

  // Stage 2: DC-balanced video or table symbol; non-video clears bias
  always_comb begin
    sym_d  = sym_q;
    bias_d = bias_q;
    case (mode_q)
      MODE_VIDEO: begin
        if ((bias_q == '0) || (disp_q == '0)) begin
          sym_d  = {~q8, q8, q8 ? qm_q[7:0] : ~qm_q[7:0]};
          bias_d = q8 ? (bias_q + disp_b) : (bias_q - disp_b);
        end else if (bias_q[BIAS_W-1] == disp_q[DISP_W-1]) begin
          sym_d  = {1'b1, q8, ~qm_q[7:0]};
          bias_d = bias_q + (q8 ? TWO : '0) - disp_b;
        end else begin
          sym_d  = {1'b0, q8, qm_q[7:0]};
          bias_d = bias_q + disp_b - (q8 ? '0 : TWO);
        end
      end
      MODE_VGUARD: begin
        sym_d  = (LANE_IDX == 1) ? VGUARD_SYM_B : VGUARD_SYM_A;
        bias_d = '0;
      end
      MODE_ISLAND: begin
        sym_d  = tbl_sym;
        bias_d = '0;
      end
      default: begin
        sym_d  = CTRL_SYM[ctrl_q];
        bias_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q  <= '0;
      bias_q <= '0;
    end else if (adv2_i) begin
      sym_q  <= sym_d;
      bias_q <= bias_d;
    end
  end

  assign sym_o = sym_q;

endmodule

// File: rtl/tmds_multi_encoder.sv
// N-lane TMDS encoder with a 2-stage pipeline, per-lane DC balance and
// control / video / guard-band / data-island periods.
// Ports: clk, rst (sync, active-high), bus (tmds_multi_encoder_if.slave:
// in_valid, in_mode, in_data, in_ctrl, in_terc4, out_valid, out_symbols).
// Macro TMDS_TERC4_EN: when defined, ISLAND slots use TERC4 coding of
// in_terc4; otherwise ISLAND is encoded as CTRL and in_terc4 is ignored.
module tmds_multi_encoder
  import tmds_multi_encoder_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned BIAS_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  tmds_multi_encoder_if.slave   bus
);

  logic                      v1_q, v2_q;
  logic [NUM_CH*SYM_W-1:0]   sym_w;

  // Slot valid pipeline; stage 2 advances only when stage 1 holds a slot
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    tmds_multi_encoder_lane_enc #(
      .LANE_IDX (i),
      .BIAS_W   (BIAS_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .adv1_i  (bus.in_valid),
      .adv2_i  (v1_q),
      .mode_i  (bus.in_mode),
      .data_i  (bus.in_data[8*i +: 8]),
      .ctrl_i  (bus.in_ctrl[2*i +: 2]),
`ifdef TMDS_TERC4_EN
      .terc4_i (bus.in_terc4[4*i +: 4]),
`endif
      .sym_o   (sym_w[SYM_W*i +: SYM_W])
    );
  end

`ifndef TMDS_TERC4_EN
  logic unused_terc4;
  assign unused_terc4 = ^bus.in_terc4;
`endif

  assign bus.out_valid   = v2_q;
  assign bus.out_symbols = sym_w;

endmodule
